// File: rtl/mccpu_mem_pkg.sv
// Shared encodings for the multicycle-CPU memory port: FSM states, access
// types and the request decode used while the port is idle.
package mccpu_mem_pkg;

    localparam int DEFAULT_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE  = 2'd0,
        REQ_FETCH = 2'd1,
        REQ_LOAD  = 2'd2,
        REQ_STORE = 2'd3
    } req_t;

    // A store beats a load when both strobes are up; strobes that do not match IorD are dropped.
    function automatic req_t decode_req(input logic iord, input logic irwrite,
                                        input logic memread, input logic memwrite);
        req_t r;
        r = REQ_NONE;
        if (!iord && irwrite)
            r = REQ_FETCH;
        else if (iord && memwrite)
            r = REQ_STORE;
        else if (iord && memread)
            r = REQ_LOAD;
        return r;
    endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Wait-cycle counter for one memory access; expire flags the last BUSY cycle
// that may still be acked before the access is declared lost.
module mem_timeout_cnt
    import mccpu_mem_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_reg;

    assign expire = enable && (count_reg == LAST);

    // Holding at LAST once expired keeps the count from ever wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_reg <= '0;
        else if (clear)
            count_reg <= '0;
        else if (enable && !expire)
            count_reg <= count_reg + CW'(1);
    end

endmodule

// File: rtl/mem_port.sv
// Memory access unit for the multicycle CPU: runs fetch/load/store on a shared
// req/ack memory, owns IR and MDR, stalls the controller and latches faults.
module mem_port
    import mccpu_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              IorD,
    input  logic              IRWrite,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] PC,
    input  logic [ADDR_W-1:0] ALUOut,
    input  logic [DATA_W-1:0] WData,
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] MDR,
    output logic              Stall,
    output logic              Fault,
    output logic [ADDR_W-1:0] FaultAddr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    state_t            state_reg, state_next;
    req_t              req_dec, type_reg;
    logic [ADDR_W-1:0] req_addr, addr_reg, fault_addr_reg;
    logic [DATA_W-1:0] wdata_reg, ir_reg, mdr_reg;
    logic              misaligned;
    logic              cnt_clear, cnt_en, cnt_expire;

    assign req_dec    = decode_req(IorD, IRWrite, MemRead, MemWrite);
    assign req_addr   = IorD ? ALUOut : PC;
    assign misaligned = |req_addr[1:0];

    assign cnt_clear = (state_reg != ST_BUSY);
    assign cnt_en    = (state_reg == ST_BUSY) && !mem_ack;

    mem_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .expire (cnt_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    // mem_req/mem_we decode straight from the state so reset drops them immediately.
    always_comb begin
        state_next = state_reg;
        Stall      = 1'b0;
        Fault      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req_dec != REQ_NONE) begin
                    Stall      = 1'b1;
                    state_next = misaligned ? ST_FAULT : ST_BUSY;
                end
            end
            ST_BUSY: begin
                Stall   = 1'b1;
                mem_req = 1'b1;
                mem_we  = (type_reg == REQ_STORE);
                if (mem_ack)
                    state_next = ST_DONE;
                else if (cnt_expire)
                    state_next = ST_FAULT;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            ST_FAULT: begin
                Stall = 1'b1;
                Fault = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg       <= '0;
            type_reg       <= REQ_NONE;
            wdata_reg      <= '0;
            ir_reg         <= '0;
            mdr_reg        <= '0;
            fault_addr_reg <= '0;
        end else begin
            if (state_reg == ST_IDLE && req_dec != REQ_NONE) begin
                if (misaligned) begin
                    fault_addr_reg <= req_addr;
                end else begin
                    addr_reg  <= req_addr;
                    type_reg  <= req_dec;
                    wdata_reg <= WData;
                end
            end
            // An ack in the expiring cycle still completes the access.
            if (state_reg == ST_BUSY) begin
                if (mem_ack) begin
                    if (type_reg == REQ_FETCH)
                        ir_reg <= mem_rdata;
                    if (type_reg == REQ_LOAD)
                        mdr_reg <= mem_rdata;
                end else if (cnt_expire) begin
                    fault_addr_reg <= addr_reg;
                end
            end
        end
    end

    assign IR        = ir_reg;
    assign MDR       = mdr_reg;
    assign FaultAddr = fault_addr_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;

endmodule

// File: doc/mem_port.md
# mem_port

Multicycle-CPU memory access unit between the `ctrl` FSM / datapath and a single shared instruction+data memory with variable-latency req/ack handshake. It serves instruction fetches (IF state) and lw/sw data accesses (MEM state), and owns the IR and MDR registers. It stalls the controller until each access completes and latches a sticky fault on misaligned addresses or memory timeout.

## Interface
- `ADDR_W`, 32, address width (byte address)
- `DATA_W`, 32, word width
- `TIMEOUT`, 16, max cycles waiting for `mem_ack` before fault (≥1)
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `IorD`  in  1  0 = fetch at `PC`, 1 = data access at `ALUOut`
- `IRWrite`  in  1  fetch request (IorD=0)
- `MemRead`  in  1  load request (IorD=1)
- `MemWrite`  in  1  store request (IorD=1)
- `PC`  in  ADDR_W  fetch address
- `ALUOut`  in  ADDR_W  data address
- `WData`  in  DATA_W  store data (register B)
- `IR`  out  DATA_W  instruction register
- `MDR`  out  DATA_W  memory data register
- `Stall`  out  1  controller must hold state and suppress PCWrite/RegWrite while 1
- `Fault`  out  1  sticky access fault
- `FaultAddr`  out  ADDR_W  address of faulting access
- `mem_req`  out  1  memory request
- `mem_we`  out  1  write enable, valid with `mem_req`
- `mem_addr`  out  ADDR_W  word-aligned byte address
- `mem_wdata`  out  DATA_W  write data
- `mem_rdata`  in  DATA_W  read data, valid when `mem_ack`=1
- `mem_ack`  in  1  access complete (one-cycle pulse)

## Operation
- Request decode (IDLE only): IorD=0 & IRWrite → FETCH; IorD=1 & MemWrite → STORE (wins over MemRead); IorD=1 & MemRead & ~MemWrite → LOAD; else none. IRWrite with IorD=1 and Mem* with IorD=0 are ignored.
- States: IDLE, BUSY, DONE, FAULT.
- IDLE: on valid request with addr[1:0]=0, register addr, type, WData → BUSY. On addr[1:0]≠0 → FAULT, `FaultAddr`=addr, no `mem_req`.
- BUSY: `mem_req`=1, `mem_we`=(type==STORE), `mem_addr`/`mem_wdata` held stable from the registered copy. On `mem_ack`: FETCH → IR←`mem_rdata`; LOAD → MDR←`mem_rdata`; STORE → no capture; → DONE. Timeout counter increments each BUSY cycle without ack; reaching TIMEOUT → FAULT, `FaultAddr`=registered addr.
- DONE: `Stall`=0 for exactly one cycle. Requests still asserted by the controller are ignored. → IDLE.
- FAULT: absorbing until reset. `Fault`=1, `Stall`=1, `mem_req`=0.
- `Stall` is combinational: 1 in IDLE when a valid request is decoded, 1 in BUSY and FAULT, 0 otherwise.
- `mem_ack` outside BUSY is ignored.
- IR and MDR change only on an acked FETCH or LOAD, respectively.

## Timing
- Reset (async, any state, including mid-access): state=IDLE, IR=0, MDR=0, Fault=0, FaultAddr=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, counter=0. `mem_req` drops immediately.
- Request seen in cycle T (`Stall`=1) → `mem_req`=1 from T+1. Ack in cycle T+k (k≥1) → IR/MDR valid and `Stall`=0 in T+k+1 → IDLE in T+k+2.
- Minimum access: 3 controller cycles (zero-wait memory acks in the first BUSY cycle).
- Timeout: `Fault` rises in cycle T+1+TIMEOUT if no ack arrives in T+1..T+TIMEOUT.
- Ack and timeout in the same cycle: ack wins.
- Counter width: $clog2(TIMEOUT+1); no wrap possible.

## Structure
- Shared package `mccpu_mem_pkg`: state encoding (IDLE/BUSY/DONE/FAULT), request-type encoding (NONE/FETCH/LOAD/STORE), default TIMEOUT.
- Sub-module `mem_timeout_cnt`: clear/enable/expire counter parameterised by TIMEOUT. All other logic lives in `mem_port`.
- Controller integration: `ctrl` gains a `MemRead` output and gates its state advance, PCWrite and RegWrite with `~Stall`.

## Test plan
- Fetch, zero-wait: IorD=0, IRWrite=1, PC=0x0000_0004, ack at T+1 with rdata=0x2008_0005 → `mem_req` only at T+1, IR=0x2008_0005 and `Stall`=0 at T+2, MDR unchanged.
- Load, 3 wait states: IorD=1, MemRead=1, ALUOut=0x100, ack at T+4 with rdata=0xDEAD_BEEF → `Stall`=1 during T..T+4, MDR=0xDEAD_BEEF at T+5, `mem_we`=0 throughout.
- Store, with MemRead also high: IorD=1, MemWrite=1, MemRead=1, ALUOut=0x200, WData=0x1234_5678 → `mem_we`=1, `mem_addr`=0x200, `mem_wdata`=0x1234_5678; IR and MDR unchanged.
- Misaligned: IorD=1, MemRead=1, ALUOut=0x102 → FAULT at T+1, FaultAddr=0x102, no `mem_req` ever, `Stall` stays 1; rst_n low clears Fault.
- Timeout: TIMEOUT=4, fetch with no ack → `Fault`=1 at T+5; ack at T+4 instead → normal completion, no fault.
- Reset mid-access: rst_n low during BUSY → `mem_req`=0 asynchronously, all outputs at reset values; a later stray `mem_ack` is ignored.
